// File: rtl/key_sw_input_port.sv
// key_sw_input_port: synchronized, debounced KEY/SW input window with sticky events and a level IRQ.
// Define KSW_READ_CLEAR_EN to make KCTRL/SCTRL reads also clear their status bits.
module key_sw_input_port #(
    parameter int DBITS           = 32,
    parameter int KEY_W           = 4,
    parameter int SW_W            = 10,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [KEY_W-1:0] KEY,
    input  logic [SW_W-1:0]  SW,
    input  logic             SEL,
    input  logic [3:0]       ADDR,
    input  logic             WE,
    input  logic [DBITS-1:0] WDATA,
    output logic [DBITS-1:0] RDATA,
    output logic             INTR
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [KEY_W-1:0] r_key_s1, r_key_s2, r_key_st, r_kst;
    logic [SW_W-1:0]  r_sw_s1, r_sw_s2, r_sw_st;
    logic [CW-1:0]    r_kcnt, r_scnt;
    logic             r_kovr, r_kie, r_schg, r_sovr, r_sie;
    logic [DBITS-1:0] r_rdata;
    logic [KEY_W-1:0] w_key_n, w_key_rise, w_kclr;
    logic             w_kdiff, w_kupd, w_sdiff, w_supd, w_wr, w_rd;
    logic             w_kovr_clr, w_schg_clr, w_sovr_clr, w_kc_rd, w_sc_rd;
    logic [DBITS-1:0] w_kctrl, w_sctrl, w_rmux;
    logic [1:0]       w_reg;
    logic             w_unused;
    always_comb begin
        w_key_n    = (KEY_ACTIVE_LOW != 0) ? ~KEY : KEY;
        w_reg      = ADDR[3:2];
        w_wr       = SEL & WE;
        w_rd       = SEL & ~WE;
        w_kdiff    = r_key_s2 != r_key_st;
        w_kupd     = w_kdiff && (r_kcnt == CMAX);
        w_sdiff    = r_sw_s2 != r_sw_st;
        w_supd     = w_sdiff && (r_scnt == CMAX);
        w_key_rise = w_kupd ? (r_key_s2 & ~r_key_st) : '0;
`ifdef KSW_READ_CLEAR_EN
        w_kc_rd    = w_rd && (w_reg == 2'd1);
        w_sc_rd    = w_rd && (w_reg == 2'd3);
`else
        w_kc_rd    = 1'b0;
        w_sc_rd    = 1'b0;
`endif
        w_kclr     = ((w_wr && w_reg == 2'd1) ? WDATA[KEY_W-1:0] : '0) | {KEY_W{w_kc_rd}};
        w_kovr_clr = (w_wr && w_reg == 2'd1 && WDATA[4]) || w_kc_rd;
        w_schg_clr = (w_wr && w_reg == 2'd3 && WDATA[0]) || w_sc_rd;
        w_sovr_clr = (w_wr && w_reg == 2'd3 && WDATA[1]) || w_sc_rd;
        w_kctrl             = '0;
        w_kctrl[KEY_W-1:0]  = r_kst;
        w_kctrl[4]          = r_kovr;
        w_kctrl[8]          = r_kie;
        w_sctrl             = '0;
        w_sctrl[0]          = r_schg;
        w_sctrl[1]          = r_sovr;
        w_sctrl[8]          = r_sie;
        w_rmux = (w_reg == 2'd0) ? DBITS'(r_key_st) :
                 (w_reg == 2'd1) ? w_kctrl :
                 (w_reg == 2'd2) ? DBITS'(r_sw_st) : w_sctrl;
        w_unused = ^{ADDR[1:0], WDATA};
    end
    // Hardware sets are ORed in after the clear so a same-cycle event always survives.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_key_st <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_sw_st  <= '0;
            r_kcnt   <= '0;
            r_scnt   <= '0;
            r_kst    <= '0;
            r_kovr   <= 1'b0;
            r_kie    <= 1'b0;
            r_schg   <= 1'b0;
            r_sovr   <= 1'b0;
            r_sie    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_key_s1 <= w_key_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
            r_kcnt   <= (!w_kdiff || w_kupd) ? '0 : r_kcnt + 1'b1;
            r_scnt   <= (!w_sdiff || w_supd) ? '0 : r_scnt + 1'b1;
            if (w_kupd) r_key_st <= r_key_s2;
            if (w_supd) r_sw_st <= r_sw_s2;
            r_kst    <= (r_kst & ~w_kclr) | w_key_rise;
            r_kovr   <= (r_kovr & ~w_kovr_clr) | (|(w_key_rise & r_kst));
            r_schg   <= (r_schg & ~w_schg_clr) | w_supd;
            r_sovr   <= (r_sovr & ~w_sovr_clr) | (w_supd & r_schg);
            if (w_wr && w_reg == 2'd1) r_kie <= WDATA[8];
            if (w_wr && w_reg == 2'd3) r_sie <= WDATA[8];
            if (w_rd) r_rdata <= w_rmux;
        end
    end
    assign RDATA = r_rdata;
    assign INTR  = (r_kie & (|r_kst)) | (r_sie & r_schg);
endmodule

// File: tb/tb_key_sw_input_port.sv
// tb_key_sw_input_port: directed scoreboard bench for key_sw_input_port with DEBOUNCE_CYCLES=4.
module tb_key_sw_input_port;
`ifdef KSW_READ_CLEAR_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        intr;
    } exp_t;
    logic        CLOCK_50 = 1'b0;
    logic        RESET, SEL, WE, INTR;
    logic [3:0]  KEY, ADDR;
    logic [9:0]  SW;
    logic [31:0] WDATA, RDATA;
    logic        rd_d = 1'b0;
    exp_t        q[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;
    key_sw_input_port #(.DBITS(32), .KEY_W(4), .SW_W(10), .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY(KEY), .SW(SW), .SEL(SEL), .ADDR(ADDR),
        .WE(WE), .WDATA(WDATA), .RDATA(RDATA), .INTR(INTR)
    );
    always #5 CLOCK_50 = ~CLOCK_50;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, x);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask
    task automatic rd(input logic [3:0] a, input logic [31:0] x, input logic xi, input string n);
        q.push_back('{name: n, rd: x, intr: xi});
        SEL = 1'b1; WE = 1'b0; ADDR = a;
        tick(1);
        SEL = 1'b0;
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        SEL = 1'b1; WE = 1'b1; ADDR = a; WDATA = d;
        tick(1);
        SEL = 1'b0; WE = 1'b0;
    endtask
    always @(posedge CLOCK_50) rd_d <= SEL & ~WE & ~RESET;
    always @(negedge CLOCK_50) begin
        if (rd_d) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_read: got 0x%0h expected no read", RDATA);
            end else begin
                e = q.pop_front();
                chk(e.name, RDATA, e.rd);
                chk({e.name, "_intr"}, {31'b0, INTR}, {31'b0, e.intr});
            end
        end
    end
    initial begin
        RESET = 1'b1; SEL = 1'b0; WE = 1'b0; ADDR = '0; WDATA = '0; KEY = 4'hF; SW = '0;
        tick(3);
        RESET = 1'b0;
        chk("reset_rdata", RDATA, 32'h0);
        chk("reset_intr", {31'b0, INTR}, 32'h0);
        wr(4'h0, 32'hF);
        rd(4'h0, 32'h0, 1'b0, "kdata_ro");
        KEY = 4'hE;
        tick(5);
        rd(4'h0, 32'h0, 1'b0, "kdata_edge6_stale");
        rd(4'h0, 32'h1, 1'b0, "kdata_press");
        rd(4'h4, 32'h1, 1'b0, "kctrl_press");
        wr(4'h4, 32'h100);
        chk("intr_kie", {31'b0, INTR}, {31'b0, !RC});
        rd(4'h4, RC ? 32'h100 : 32'h101, !RC, "kctrl_kie");
        wr(4'h4, 32'h101);
        rd(4'h4, 32'h100, 1'b0, "kctrl_w1c");
        KEY = 4'hF;
        tick(7);
        rd(4'h0, 32'h0, 1'b0, "kdata_release");
        rd(4'h4, 32'h100, 1'b0, "kctrl_release");
        wr(4'h4, 32'h0);
        KEY = 4'hD;
        tick(3);
        KEY = 4'hF;
        tick(6);
        rd(4'h0, 32'h0, 1'b0, "kdata_glitch");
        rd(4'h4, 32'h0, 1'b0, "kctrl_glitch");
        KEY = 4'hD;
        tick(6);
        rd(4'h0, 32'h2, 1'b0, "kdata_key1");
        rd(4'h4, 32'h2, 1'b0, "kctrl_key1");
        KEY = 4'hF;
        tick(8);
        wr(4'h4, 32'h2);
        KEY = 4'hB; tick(8); KEY = 4'hF; tick(8);
        KEY = 4'hB; tick(8); KEY = 4'hF; tick(8);
        rd(4'h4, 32'h14, 1'b0, "kctrl_overrun");
        wr(4'h4, 32'h14);
        rd(4'h4, 32'h0, 1'b0, "kctrl_overrun_clr");
        KEY = 4'hE; tick(8); KEY = 4'hF; tick(8);
        KEY = 4'hE;
        tick(5);
        wr(4'h4, 32'h1);
        rd(4'h4, 32'h11, 1'b0, "kctrl_set_wins");
        KEY = 4'hF;
        tick(8);
        wr(4'h4, 32'h11);
        rd(4'h4, 32'h0, 1'b0, "kctrl_collision_clr");
        wr(4'hC, 32'h100);
        SW = 10'h2A5;
        tick(5);
        rd(4'h8, 32'h0, 1'b1, "sdata_edge6_stale");
        rd(4'h8, 32'h2A5, 1'b1, "sdata_change");
        rd(4'hC, 32'h101, !RC, "sctrl_change");
        wr(4'hC, 32'h101);
        rd(4'hC, 32'h100, 1'b0, "sctrl_w1c");
        SW = 10'h000; tick(8);
        SW = 10'h001; tick(8);
        rd(4'hC, 32'h103, !RC, "sctrl_overrun");
        SW = 10'h000; tick(8);
        wr(4'hC, 32'h3);
        rd(4'hC, 32'h0, 1'b0, "sctrl_clr");
        wr(4'h4, 32'h100);
        rd(4'h4, 32'h100, 1'b0, "kctrl_pre_reset");
        KEY = 4'h7;
        tick(3);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        KEY = 4'hF;
        chk("midreset_rdata", RDATA, 32'h0);
        chk("midreset_intr", {31'b0, INTR}, 32'h0);
        tick(8);
        rd(4'h0, 32'h0, 1'b0, "kdata_discarded");
        rd(4'h4, 32'h0, 1'b0, "kctrl_discarded");
        KEY = 4'h7;
        tick(3);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        tick(6);
        rd(4'h0, 32'h8, 1'b0, "kdata_still_differs");
        rd(4'h4, 32'h8, 1'b0, "kctrl_first_read");
        rd(4'h4, RC ? 32'h0 : 32'h8, 1'b0, "kctrl_second_read");
        tick(2);
        chk("queue_drained", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/key_sw_input_port.md
Name: key_sw_input_port

Overview:
- Memory-mapped input peripheral that reads the board KEY and SW inputs of project3_frame for the RISC core.
- Synchronizes and debounces both input groups, and captures key-press and switch-change events in sticky status bits.
- Raises an interrupt request when an enabled event is pending.
- Sits on the core's data bus as a 4-word I/O register window.

Parameters:
DBITS, 32, data bus width
KEY_W, 4, number of KEY inputs
SW_W, 10, number of SW inputs
KEY_ACTIVE_LOW, 1, 1 = KEY pin low means pressed
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed before accepting a change (10 ms at 50 MHz); minimum 2

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
KEY  in  KEY_W  raw asynchronous pushbutton pins
SW  in  SW_W  raw asynchronous slide-switch pins
SEL  in  1  bus select for this window
ADDR  in  4  byte offset; ADDR[3:2] picks the register, ADDR[1:0] ignored
WE  in  1  write strobe, qualified by SEL
WDATA  in  DBITS  write data
RDATA  out  DBITS  registered read data
INTR  out  1  interrupt request, level

Behaviour:
- Interface: one clock (CLOCK_50); reset is synchronous and active-high (RESET).
- Synchronizers: 2 flops per input bit.
  - KEY is normalized to pressed=1 when KEY_ACTIVE_LOW=1.
  - Reset value of the synchronizer flops is the normalized idle value, 0.
- Debounce, one counter per group (key group and switch group):
  - Counter resets to 0 whenever the synchronized value equals the stable value.
  - Otherwise it increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable <= synchronized value and the counter resets to 0.
  - A bounce restarts the count.
  - Latency from pin change to stable update: 2+DEBOUNCE_CYCLES cycles.
- Registers (word offsets):
  - 0x0 KDATA (RO): [KEY_W-1:0] stable key state, 1 = pressed.
  - 0x4 KCTRL:
    - [KEY_W-1:0] press sticky bits, W1C.
    - [4] key overrun, W1C.
    - [8] KIE, R/W.
  - 0x8 SDATA (RO): [SW_W-1:0] stable switch state.
  - 0xC SCTRL:
    - [0] switch-changed sticky, W1C.
    - [1] switch overrun, W1C.
    - [8] SIE, R/W.
  - All unlisted bits read 0. Writes to read-only registers are ignored.
- Event capture:
  - A stable key bit rising 0->1 sets its sticky bit. If that bit is already set, key overrun is set as well.
  - A key release sets nothing.
  - Any change of the stable SW vector sets switch-changed. If it is already set, switch overrun is set.
- Hardware set and software W1C clear in the same cycle: the set wins.
- Read timing:
  - Read occurs when SEL=1 and WE=0; RDATA is valid on the next cycle.
  - RDATA holds its last value when not selected.
  - SEL=1 with WE=1 writes on that edge; RDATA is unchanged.
- INTR = (KIE & |key sticky) | (SIE & switch-changed), driven from flops only, with no combinational path from the bus.
- Reset values: RDATA=0, INTR=0, all sticky/overrun/IE bits 0, stable states 0, counters 0.
  - If SW is non-zero at reset release, switch-changed sets 2+DEBOUNCE_CYCLES cycles later.
- Reset asserted mid-debounce or mid-access: the pending change is discarded and the state returns to reset values on that edge.

Optional Feature:
- Macro: KSW_READ_CLEAR_EN.
- When defined:
  - A read of KCTRL clears all key sticky bits and key overrun on the read edge.
  - A read of SCTRL clears switch-changed and switch overrun likewise.
  - RDATA returns the pre-clear value.
  - A hardware set in the same cycle still wins.
- When undefined: reads have no side effects, and clearing is by W1C only.

Test Plan:
(DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1)
- Key press: KEY=4'hE held -> KDATA reads 0x1 and KCTRL[0]=1 exactly 6 cycles after the pin change; INTR stays 0 (KIE=0). Then write KCTRL=0x100 -> INTR=1 next cycle; write KCTRL=0x101 -> KCTRL reads 0x100, INTR=0.
- Glitch reject: KEY[1] low for 3 cycles then high -> KDATA stays 0x0, KCTRL[1]=0; KEY[1] low for 6 cycles -> KDATA=0x2.
- Overrun: press/release KEY[2] twice with no clear -> KCTRL reads 0x014; write 0x014 -> reads 0x000.
- Switch: SW 0x000->0x2A5, SCTRL=0x100 -> SDATA=0x2A5, SCTRL reads 0x101, INTR=1 after 6 cycles.
- Collision and reset: W1C of KCTRL[0] on the same edge as a new KEY[0] press -> bit reads 1. RESET pulsed 3 cycles into a debounce -> KDATA=0, KCTRL=0, RDATA=0, INTR=0, and no event is captured afterwards for the discarded change unless the pin still differs.
- With KSW_READ_CLEAR_EN: press KEY[3] -> first KCTRL read returns 0x008, second read returns 0x000.
